// File: rtl/mem_bus_arbiter_if.sv
// Bundle of the fetch, load/store and system-bus signals around mem_bus_arbiter.
// The master modport is the arbiter's view; slave is the requesters' and memory's view.
interface mem_bus_arbiter_if #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_resp_valid;
    logic [DATA_W-1:0] if_resp_data;
    logic              if_done;

    logic              d_req;
    logic [ADDR_W-1:0] d_addr;
    logic              d_write;
    logic [DATA_W-1:0] d_wdata;
    logic [2:0]        d_size;
    logic              d_gnt;
    logic              d_resp_valid;
    logic [DATA_W-1:0] d_resp_data;
    logic              d_done;

    logic              bus_req;
    logic [ADDR_W-1:0] bus_addr;
    logic              bus_write;
    logic [DATA_W-1:0] bus_wdata;
    logic [2:0]        bus_size;
    logic              bus_ack;
    logic              bus_resp_valid;
    logic [DATA_W-1:0] bus_resp_data;
    logic              bus_resp_ack;

    modport master (
        input  if_req, if_addr,
        output if_gnt, if_resp_valid, if_resp_data, if_done,
        input  d_req, d_addr, d_write, d_wdata, d_size,
        output d_gnt, d_resp_valid, d_resp_data, d_done,
        output bus_req, bus_addr, bus_write, bus_wdata, bus_size,
        input  bus_ack, bus_resp_valid, bus_resp_data,
        output bus_resp_ack
    );

    modport slave (
        output if_req, if_addr,
        input  if_gnt, if_resp_valid, if_resp_data, if_done,
        output d_req, d_addr, d_write, d_wdata, d_size,
        input  d_gnt, d_resp_valid, d_resp_data, d_done,
        input  bus_req, bus_addr, bus_write, bus_wdata, bus_size,
        output bus_ack, bus_resp_valid, bus_resp_data,
        input  bus_resp_ack
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// Round-robin sharing of the single memory port between instruction fetch and
// load/store: one transaction at a time (arbitrate, issue, collect beats, complete).
module mem_bus_arbiter #(
    parameter int unsigned ADDR_W = 64,
    parameter int unsigned DATA_W = 64,
    parameter int unsigned BEATS  = 8
) (
    input logic               clk,
    input logic               reset,
    mem_bus_arbiter_if.master io_mb
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] REQ_I  = 3'd1;
    localparam logic [2:0] REQ_D  = 3'd2;
    localparam logic [2:0] RESP_I = 3'd3;
    localparam logic [2:0] RESP_D = 3'd4;

    localparam logic [2:0] MEM_DOUBLE = 3'd3;

    localparam int unsigned      CNT_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BEATS - 1);

    logic [2:0]        r_state;
    logic              r_last_d;
    logic [CNT_W-1:0]  r_cnt;

    logic              r_bus_req;
    logic [ADDR_W-1:0] r_bus_addr;
    logic              r_bus_write;
    logic [DATA_W-1:0] r_bus_wdata;
    logic [2:0]        r_bus_size;

    logic              r_if_gnt;
    logic              r_if_rv;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_if_done;
    logic              r_d_gnt;
    logic              r_d_rv;
    logic [DATA_W-1:0] r_d_rdata;
    logic              r_d_done;

    logic              w_in_resp;
    logic              w_last_beat;
    logic              w_pick_d;

    assign w_in_resp   = (r_state == RESP_I) || (r_state == RESP_D);
    assign w_last_beat = (r_cnt == LAST_CNT);
    // Data wins when alone, or on a tie when fetch was the last one served.
    assign w_pick_d    = io_mb.d_req && (!io_mb.if_req || !r_last_d);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_last_d    <= 1'b0;
            r_cnt       <= '0;
            r_bus_req   <= 1'b0;
            r_bus_addr  <= '0;
            r_bus_write <= 1'b0;
            r_bus_wdata <= '0;
            r_bus_size  <= '0;
            r_if_gnt    <= 1'b0;
            r_if_rv     <= 1'b0;
            r_if_rdata  <= '0;
            r_if_done   <= 1'b0;
            r_d_gnt     <= 1'b0;
            r_d_rv      <= 1'b0;
            r_d_rdata   <= '0;
            r_d_done    <= 1'b0;
        end else begin
            r_if_gnt  <= 1'b0;
            r_if_rv   <= 1'b0;
            r_if_done <= 1'b0;
            r_d_gnt   <= 1'b0;
            r_d_rv    <= 1'b0;
            r_d_done  <= 1'b0;

            case (r_state)
                IDLE: begin
                    if (w_pick_d) begin
                        r_bus_req   <= 1'b1;
                        r_bus_addr  <= io_mb.d_addr;
                        r_bus_write <= io_mb.d_write;
                        r_bus_wdata <= io_mb.d_wdata;
                        r_bus_size  <= io_mb.d_size;
                        r_last_d    <= 1'b1;
                        r_state     <= REQ_D;
                    end else if (io_mb.if_req) begin
                        r_bus_req   <= 1'b1;
                        r_bus_addr  <= io_mb.if_addr;
                        r_bus_write <= 1'b0;
                        r_bus_wdata <= '0;
                        r_bus_size  <= MEM_DOUBLE;
                        r_last_d    <= 1'b0;
                        r_state     <= REQ_I;
                    end
                end
                REQ_I: begin
                    if (io_mb.bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_if_gnt  <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= RESP_I;
                    end
                end
                REQ_D: begin
                    if (io_mb.bus_ack) begin
                        r_bus_req <= 1'b0;
                        r_d_gnt   <= 1'b1;
                        // Stores carry no response beats and complete on acceptance.
                        if (r_bus_write) begin
                            r_d_done <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            r_cnt    <= '0;
                            r_state  <= RESP_D;
                        end
                    end
                end
                RESP_I: begin
                    if (io_mb.bus_resp_valid) begin
                        r_if_rv    <= 1'b1;
                        r_if_rdata <= io_mb.bus_resp_data;
                        if (w_last_beat) begin
                            r_if_done <= 1'b1;
                            r_state   <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                RESP_D: begin
                    if (io_mb.bus_resp_valid) begin
                        r_d_rv    <= 1'b1;
                        r_d_rdata <= io_mb.bus_resp_data;
                        if (w_last_beat) begin
                            r_d_done <= 1'b1;
                            r_state  <= IDLE;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign io_mb.bus_resp_ack  = w_in_resp && io_mb.bus_resp_valid;

    assign io_mb.bus_req       = r_bus_req;
    assign io_mb.bus_addr      = r_bus_addr;
    assign io_mb.bus_write     = r_bus_write;
    assign io_mb.bus_wdata     = r_bus_wdata;
    assign io_mb.bus_size      = r_bus_size;

    assign io_mb.if_gnt        = r_if_gnt;
    assign io_mb.if_resp_valid = r_if_rv;
    assign io_mb.if_resp_data  = r_if_rdata;
    assign io_mb.if_done       = r_if_done;
    assign io_mb.d_gnt         = r_d_gnt;
    assign io_mb.d_resp_valid  = r_d_rv;
    assign io_mb.d_resp_data   = r_d_rdata;
    assign io_mb.d_done        = r_d_done;
endmodule

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Sequences and shares the single system memory port between the instruction-fetch requester and the load/store data requester. Fetch feeds the decoder. Data requests come from decoded loads and stores: mem_access, mem_size. The block runs one bus transaction at a time: arbitrate, issue, collect the response burst, signal completion. Arbitration between the two requesters is round-robin.

## Interface
- ADDR_W, 64, address width
- DATA_W, 64, bus data and beat width
- BEATS, 8, response beats per read transaction (≥1)
- clk  in  1  clock
- reset  in  1  synchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr until if_gnt
- if_addr  in  ADDR_W  fetch address
- if_gnt  out  1  one-cycle pulse: fetch request accepted by bus
- if_resp_valid  out  1  fetch beat valid
- if_resp_data  out  DATA_W  fetch beat data
- if_done  out  1  one-cycle pulse: fetch transaction complete
- d_req  in  1  data request; held with d_addr/d_write/d_wdata/d_size until d_gnt
- d_addr  in  ADDR_W  data address
- d_write  in  1  1 = store, 0 = load
- d_wdata  in  DATA_W  store data
- d_size  in  3  mem_size code (MEM_* encoding)
- d_gnt, d_resp_valid, d_resp_data, d_done  out  1/1/DATA_W/1  data-side equivalents of the if_ outputs
- bus_req  out  1  bus request
- bus_addr  out  ADDR_W  bus address
- bus_write  out  1  bus write enable
- bus_wdata  out  DATA_W  bus write data
- bus_size  out  3  bus access size; MEM_DOUBLE for fetch
- bus_ack  in  1  bus accepted request
- bus_resp_valid  in  1  response beat valid
- bus_resp_data  in  DATA_W  response beat data
- bus_resp_ack  out  1  beat accepted

## Operation
- FSM states: IDLE, REQ_I, REQ_D, RESP_I, RESP_D.
- **IDLE, arbitration:**
  - Only if_req high -> REQ_I.
  - Only d_req high -> REQ_D.
  - Both high -> grant the requester not equal to last_served.
  - last_served resets to I, so the first tie after reset goes to data.
- **On entering REQ_x:**
  - Register the selected address, write, wdata and size onto the bus_* outputs.
  - Fetch drives bus_write=0, bus_wdata=0, bus_size=MEM_DOUBLE.
  - Set last_served = x.
- **REQ_x:**
  - bus_req stays high until bus_ack is sampled high.
  - On bus_ack: pulse x_gnt and clear bus_req.
  - On bus_ack, a read goes to RESP_x with beat counter = 0.
  - On bus_ack, a write also pulses x_done and goes to IDLE. Writes have no response beats.
- **RESP_x:**
  - bus_resp_ack = bus_resp_valid (combinational). It is 0 in every other state.
  - Each accepted beat is registered to x_resp_valid/x_resp_data and the counter increments.
  - When the beat with counter = BEATS-1 is accepted, go to IDLE and pulse x_done coincident with that beat's x_resp_valid.
- Counter width is clog2(BEATS) with a minimum of 1. It never wraps within a transaction, because it is cleared on entry to RESP_x.
- **Ignored inputs:**
  - bus_resp_valid outside RESP_x: no effect on any output.
  - bus_ack outside REQ_x: ignored.
  - Requests arriving outside IDLE wait. They are held by the requester.
- **Reset (low at a clock edge, including mid-transaction):**
  - State -> IDLE, last_served -> I, counter -> 0.
  - All outputs -> 0, including bus_req, all bus_* fields, gnt, resp_valid, resp_data and done.
  - In-flight beats are dropped; nothing is replayed.

## Timing
- All outputs are registered except bus_resp_ack.
- Request is high at edge N in IDLE -> bus_req high from cycle N+1.
- bus_ack is high at edge M -> x_gnt high for cycle M+1 only, and bus_req low at M+1.
- For a write, x_done is also high at M+1 only.
- Beat sampled at edge K -> x_resp_valid/data at K+1 for one cycle. Beats need not be consecutive.
- Last beat at edge L -> x_done at L+1 and state is IDLE at L+1.
- A request sampled at edge L+1 gives the next bus_req at L+2.
- Minimum read occupancy: 1 (IDLE) + 1 (bus_ack in the first REQ cycle) + BEATS cycles.
- gnt, done and resp_valid never assert for the requester not being served.

## Test plan
- **Single fetch:** if_req=1, if_addr=0x1000; bus_ack 2 cycles after bus_req; 8 consecutive beats 0..7 -> bus_addr=0x1000, bus_size=MEM_DOUBLE, bus_write=0, one if_gnt pulse, 8 if_resp_valid beats with data 0..7 each 1 cycle late, if_done with beat 7, d_* outputs all 0.
- **Store:** d_req, d_write=1, d_addr=0x2008, d_wdata=0xDEADBEEF, d_size=MEM_WORD; bus_ack -> d_gnt and d_done in the same cycle (M+1), no d_resp_valid, state IDLE.
- **Contention:** if_req and d_req held high together from reset for 4 transactions -> service order D, I, D, I; no gnt for the waiting side.
- **Gapped beats:** bus_resp_valid toggling 1,0,1,0 across 8 beats -> exactly 8 if_resp_valid pulses, if_done on the 8th only. Stray bus_resp_valid while in IDLE -> no output activity and bus_resp_ack=0.
- **Reset mid-burst:** reset low after beat 3 of a load -> next cycle all outputs 0 and state IDLE. After release, a new d_req wins a tie against if_req (last_served = I).
- **Back-to-back:** d_req held across the last beat of a fetch -> bus_req for data rises exactly 2 cycles after the last fetch beat is sampled.
